regfile_sb: RTL and testbench

- Parametrised multi-register successor to the single 32-bit CPU data register.
- Holds NREGS general-purpose registers with one write port and two combinational read ports.
- Carries a per-register pending-write scoreboard so the pipelined CPU control can detect RAW hazards and flush in-flight reservations.
- Sits between decode (read, reserve) and writeback (write, release).

---
 rtl/regfile_sb.sv | 107 ++++++++++
 tb/tb_regfile_sb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with one write port, two combinational read ports and a
// per-register pending-write scoreboard. Optional forward: REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CNT_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  output logic              sb_err
);

  localparam int unsigned NREGS = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];
  logic [CNT_W-1:0]  cnt_q [NREGS];
  logic [CNT_W-1:0]  cnt_d [NREGS];
  logic              err_q;
  logic              err_d;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // State updates on the falling edge; reset wins over everything.
  always_ff @(negedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        mem_q[r] <= mem_d[r];
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  // Data write plus per-register reserve/release bookkeeping.
  always_comb begin
    logic inc;
    logic dec;
    for (int unsigned r = 0; r < NREGS; r++) begin
      mem_d[r] = mem_q[r];
      cnt_d[r] = cnt_q[r];
    end
    err_d = err_q;
    inc   = 1'b0;
    dec   = 1'b0;

    if (we && !is_zero_reg(waddr)) mem_d[waddr] = wdata;

    for (int unsigned r = 0; r < NREGS; r++) begin
      inc = rsv_en && (rsv_addr == ADDR_W'(r));
      dec = we && (waddr == ADDR_W'(r));
      if (is_zero_reg(ADDR_W'(r)) || flush) begin
        cnt_d[r] = '0;
      end else if (inc && !dec) begin
        if (cnt_q[r] == CNT_MAX) err_d = 1'b1;
        else                     cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec && !inc) begin
        if (cnt_q[r] == '0) err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  // Combinational read ports and hazard flags.
  always_comb begin
    rdata_a = is_zero_reg(raddr_a) ? '0 : mem_q[raddr_a];
    rdata_b = is_zero_reg(raddr_b) ? '0 : mem_q[raddr_b];
    busy_a  = !is_zero_reg(raddr_a) && (cnt_q[raddr_a] != '0);
    busy_b  = !is_zero_reg(raddr_b) && (cnt_q[raddr_b] != '0);
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write; its reservation is the last one unless re-reserved.
    if (we && (waddr == raddr_a) && !is_zero_reg(raddr_a)) begin
      rdata_a = wdata;
      if ((cnt_q[raddr_a] == CNT_W'(1)) && !(rsv_en && (rsv_addr == raddr_a))) busy_a = 1'b0;
    end
    if (we && (waddr == raddr_b) && !is_zero_reg(raddr_b)) begin
      rdata_b = wdata;
      if ((cnt_q[raddr_b] == CNT_W'(1)) && !(rsv_en && (rsv_addr == raddr_b))) busy_b = 1'b0;
    end
`endif
  end

  assign sb_err = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb (default parameters).
module tb_regfile_sb;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [31:0] rdata_a;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_b;
  logic        busy_a;
  logic        busy_b;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        flush;
  logic        sb_err;

  typedef struct {
    string       tag;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        ba;
    logic        bb;
    logic        er;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_sb dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .busy_a(busy_a), .busy_b(busy_b), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .flush(flush), .sb_err(sb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input string tag, input logic [31:0] ra, input logic [31:0] rb,
                      input logic ba, input logic bb, input logic er);
    exp_t e;
    e.tag = tag; e.ra = ra; e.rb = rb; e.ba = ba; e.bb = bb; e.er = er;
    exp_q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard empty: got nothing, required an entry");
      return;
    end
    e = exp_q.pop_front();
    checks++;
    assert (rdata_a === e.ra) else begin
      errors++; $error("FAIL %s rdata_a got %h exp %h", e.tag, rdata_a, e.ra);
    end
    checks++;
    assert (rdata_b === e.rb) else begin
      errors++; $error("FAIL %s rdata_b got %h exp %h", e.tag, rdata_b, e.rb);
    end
    checks++;
    assert (busy_a === e.ba) else begin
      errors++; $error("FAIL %s busy_a got %b exp %b", e.tag, busy_a, e.ba);
    end
    checks++;
    assert (busy_b === e.bb) else begin
      errors++; $error("FAIL %s busy_b got %b exp %b", e.tag, busy_b, e.bb);
    end
    checks++;
    assert (sb_err === e.er) else begin
      errors++; $error("FAIL %s sb_err got %b exp %b", e.tag, sb_err, e.er);
    end
  endtask

  // Drive controls just after the rising edge so they are stable at the falling edge.
  task automatic apply(input logic rst, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rs, input logic [4:0] ra, input logic fl);
    @(posedge clk);
    #1;
    reset = rst; we = w; waddr = wa; wdata = wd; rsv_en = rs; rsv_addr = ra; flush = fl;
  endtask

  // Let the falling edge commit, then drop controls so reads see stored state only.
  task automatic finish_cycle();
    @(negedge clk);
    #1;
    reset = 1'b0; we = 1'b0; rsv_en = 1'b0; flush = 1'b0;
    #1;
  endtask

  task automatic cyc(input logic rst, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic rs, input logic [4:0] ra, input logic fl);
    apply(rst, w, wa, wd, rs, ra, fl);
    finish_cycle();
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    raddr_a = a;
    raddr_b = b;
    #1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;

    // 1: reset state on every address, then a reserved write to r5
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      push("reset_read", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check();
    end
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0);
    rd(5'd5, 5'd0);
    push("rsv_r5", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check();
    cyc(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    rd(5'd5, 5'd6);
    push("write_r5", 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0);
    check();

    // 2: register 0 ignores writes and reservations
    cyc(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0);
    rd(5'd0, 5'd5);
    push("r0_write", 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    check();
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
    rd(5'd0, 5'd0);
    push("r0_rsv", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check();

    // 3: counter saturation on r7 and release after three writes
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    rd(5'd7, 5'd5);
    push("r7_rsv3", 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    check();
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    push("r7_sat", 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
    check();
    cyc(1'b0, 1'b1, 5'd7, 32'h71, 1'b0, 5'd0, 1'b0);
    push("r7_w1", 32'h71, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
    check();
    cyc(1'b0, 1'b1, 5'd7, 32'h72, 1'b0, 5'd0, 1'b0);
    push("r7_w2", 32'h72, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
    check();
    cyc(1'b0, 1'b1, 5'd7, 32'h73, 1'b0, 5'd0, 1'b0);
    push("r7_w3", 32'h73, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    check();

    // 4: simultaneous reserve+release on r3, then flush with a write
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
    cyc(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 1'b0);
    rd(5'd3, 5'd7);
    push("r3_rsv_wr", 32'h33, 32'h73, 1'b1, 1'b0, 1'b1);
    check();
    cyc(1'b0, 1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 1'b1);
    push("r3_flush", 32'h1234, 32'h73, 1'b0, 1'b0, 1'b1);
    check();

    // 5: unreserved write flags an error; reset mid-sequence clears everything
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    cyc(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b0);
    rd(5'd9, 5'd3);
    push("r9_unrsv", 32'h99, 32'h0, 1'b0, 1'b0, 1'b1);
    check();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
    cyc(1'b0, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 1'b0);
    push("r9_cnt2", 32'h55, 32'h0, 1'b1, 1'b0, 1'b1);
    check();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    push("mid_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check();

    // 6: write-to-read forwarding before the falling edge
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0);
    cyc(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 1'b0);
    rd(5'd9, 5'd4);
    push("r4_old", 32'h0, 32'h44, 1'b0, 1'b1, 1'b0);
    check();
    apply(1'b0, 1'b1, 5'd4, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0);
    #1;
`ifdef REGFILE_BYPASS_EN
    push("bypass_pre", 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
`else
    push("bypass_pre", 32'h0, 32'h44, 1'b0, 1'b1, 1'b0);
`endif
    check();
    finish_cycle();
    push("bypass_post", 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
